// File: rtl/reset_teardown_sequencer.sv
// Reverse-order stage reset teardown: waits for each stage to go idle, or times out, then resets it.
// Define TEARDOWN_ABORT_EN to add abort_req/aborted, which cancel the teardown from WAIT3.
//   state | meaning
//   RUN   | normal operation, watching shutdown_req
//   WAIT3 | waiting for stage3 idle or timeout, then assert reset3
//   GAP3  | spacing delay after reset3
//   WAIT2 | waiting for stage2 idle or timeout, then assert reset2
//   GAP2  | spacing delay after reset2
//   WAIT1 | waiting for stage1 idle or timeout, then assert reset1
//   DONE  | all stage resets held, absorbing until ext_reset_n
module reset_teardown_sequencer #(
  parameter int GAP          = 10,
  parameter int IDLE_TIMEOUT = 255,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       ext_reset_n,
  input  logic       shutdown_req,
  input  logic [2:0] stage_idle,
`ifdef TEARDOWN_ABORT_EN
  input  logic       abort_req,
  output logic       aborted,
`endif
  output logic       reset1,
  output logic       reset2,
  output logic       reset3,
  output logic       busy,
  output logic       shutdown_done,
  output logic [2:0] timeout_err
);

  localparam int MAX_CNT = ((GAP > IDLE_TIMEOUT) ? GAP : IDLE_TIMEOUT) - 1;

  generate
    if (GAP < 1 || IDLE_TIMEOUT < 1 || (MAX_CNT >> CNT_W) != 0) begin : g_bad_param
      $error("reset_teardown_sequencer: GAP/IDLE_TIMEOUT must be >= 1 and fit in CNT_W");
    end
  endgenerate

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(IDLE_TIMEOUT - 1);

  typedef enum logic [2:0] {RUN, WAIT3, GAP3, WAIT2, GAP2, WAIT1, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             cur_idle;
  logic             to_hit;
  logic             gap_hit;

  // Idle bit of whichever stage the current WAIT state is draining
  always_comb begin
    cur_idle = 1'b0;
    case (state)
      WAIT3:   cur_idle = stage_idle[2];
      WAIT2:   cur_idle = stage_idle[1];
      WAIT1:   cur_idle = stage_idle[0];
      default: cur_idle = 1'b0;
    endcase
  end

  assign to_hit  = (cnt == TO_LAST);
  assign gap_hit = (cnt == GAP_LAST);

  always_ff @(posedge clk or negedge ext_reset_n) begin
    if (!ext_reset_n) begin
      state         <= RUN;
      cnt           <= '0;
      reset1        <= 1'b0;
      reset2        <= 1'b0;
      reset3        <= 1'b0;
      busy          <= 1'b0;
      shutdown_done <= 1'b0;
      timeout_err   <= 3'b000;
`ifdef TEARDOWN_ABORT_EN
      aborted       <= 1'b0;
`endif
    end else begin
`ifdef TEARDOWN_ABORT_EN
      aborted <= 1'b0;
`endif
      case (state)
        RUN: begin
          if (shutdown_req) begin
            state <= WAIT3;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        WAIT3: begin
`ifdef TEARDOWN_ABORT_EN
          // Abort takes priority over an idle/timeout assert on the same edge
          if (abort_req) begin
            state   <= RUN;
            cnt     <= '0;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else
`endif
          if (cur_idle || to_hit) begin
            reset3 <= 1'b1;
            if (!cur_idle) timeout_err[2] <= 1'b1;
            state  <= GAP3;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP3: begin
          if (gap_hit) begin
            state <= WAIT2;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT2: begin
          if (cur_idle || to_hit) begin
            reset2 <= 1'b1;
            if (!cur_idle) timeout_err[1] <= 1'b1;
            state  <= GAP2;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP2: begin
          if (gap_hit) begin
            state <= WAIT1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT1: begin
          if (cur_idle || to_hit) begin
            reset1        <= 1'b1;
            if (!cur_idle) timeout_err[0] <= 1'b1;
            shutdown_done <= 1'b1;
            busy          <= 1'b0;
            state         <= DONE;
            cnt           <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
